// File: rtl/pupil_track_ctrl_if.sv
// Frame-rate handshake between the detector pair and the pupil tracking controller.
// Box format: {flag, ymax[9:0], xmax[10:0], ymin[9:0], xmin[10:0]}.
interface pupil_track_ctrl_if;
  logic        per_frame_vsync;
  logic [42:0] eye_pos_in;
  logic [42:0] pupil_pos_in;
  logic [42:0] win_pos_out;
  logic [1:0]  track_state;
  logic [10:0] center_x;
  logic [9:0]  center_y;
  logic        center_valid;
  logic [2:0]  lost_cnt;

  modport master (
    output per_frame_vsync, eye_pos_in, pupil_pos_in,
    input  win_pos_out, track_state, center_x, center_y, center_valid, lost_cnt
  );
  modport slave (
    input  per_frame_vsync, eye_pos_in, pupil_pos_in,
    output win_pos_out, track_state, center_x, center_y, center_valid, lost_cnt
  );
endinterface

// File: rtl/pupil_track_ctrl.sv
// Acquire/track/coast controller: picks next frame's search window and pupil centre at frame end.
// Optional PUPIL_TRACK_SMOOTH_EN averages the window on consecutive TRACK hits.
module pupil_track_ctrl #(
  parameter int IMG_HDISP = 1280,
  parameter int IMG_VDISP = 720,
  parameter int LOCK_CNT  = 3,
  parameter int LOST_MAX  = 4
)(
  input  logic             clk,
  input  logic             rst_n,
  pupil_track_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2, COAST = 2'd3} state_t;
  typedef struct packed {
    logic        flag;
    logic [9:0]  ymax;
    logic [10:0] xmax;
    logic [9:0]  ymin;
    logic [10:0] xmin;
  } box_t;

  localparam logic [10:0] XMIN_LO = 11'd20;
  localparam logic [9:0]  YMIN_LO = 10'd32;
  localparam logic [10:0] XMAX_HI = 11'(IMG_HDISP - 21);
  localparam logic [9:0]  YMAX_HI = 10'(IMG_VDISP - 21);
  localparam logic [2:0]  LOCK_N  = 3'(LOCK_CNT);
  localparam logic [2:0]  LOST_N  = 3'(LOST_MAX);

  // Keeps the downstream +20/-32 window expansion from wrapping.
  function automatic box_t clamp_box(input box_t b);
    box_t c;
    c = b;
    if (b.xmin < XMIN_LO) c.xmin = XMIN_LO;
    if (b.ymin < YMIN_LO) c.ymin = YMIN_LO;
    if (b.xmax > XMAX_HI) c.xmax = XMAX_HI;
    if (b.ymax > YMAX_HI) c.ymax = YMAX_HI;
    return c;
  endfunction

`ifdef PUPIL_TRACK_SMOOTH_EN
  function automatic box_t avg_box(input box_t o, input box_t n);
    box_t a;
    a.flag = n.flag;
    a.xmin = 11'(({1'b0, o.xmin} + {1'b0, n.xmin}) >> 1);
    a.xmax = 11'(({1'b0, o.xmax} + {1'b0, n.xmax}) >> 1);
    a.ymin = 10'(({1'b0, o.ymin} + {1'b0, n.ymin}) >> 1);
    a.ymax = 10'(({1'b0, o.ymax} + {1'b0, n.ymax}) >> 1);
    return a;
  endfunction
`endif

  state_t      state;
  box_t        win_q, eye, pupil, eye_win, pupil_win;
  logic        vsync_r, smp, hit, valid;
  logic [2:0]  hit_cnt, lost;
  logic [10:0] cx, cx_next;
  logic [9:0]  cy, cy_next;

  assign eye   = bus.eye_pos_in;
  assign pupil = bus.pupil_pos_in;
  assign hit   = pupil.flag && (pupil.xmax >= pupil.xmin) && (pupil.ymax >= pupil.ymin);
  assign eye_win = clamp_box(eye);

  always_comb begin
    pupil_win = clamp_box(pupil);
`ifdef PUPIL_TRACK_SMOOTH_EN
    if (state == TRACK) pupil_win = clamp_box(avg_box(win_q, pupil));
`endif
  end

  assign cx_next = 11'(({1'b0, pupil_win.xmin} + {1'b0, pupil_win.xmax}) >> 1);
  assign cy_next = 10'(({1'b0, pupil_win.ymin} + {1'b0, pupil_win.ymax}) >> 1);

  // smp is the registered frame-end pulse; every update waits for it so the window is frozen mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r <= 1'b0;
      smp     <= 1'b0;
      state   <= IDLE;
      hit_cnt <= '0;
      lost    <= '0;
      win_q   <= '0;
      cx      <= '0;
      cy      <= '0;
      valid   <= 1'b0;
    end else begin
      vsync_r <= bus.per_frame_vsync;
      smp     <= vsync_r & ~bus.per_frame_vsync;
      if (smp) begin
        case (state)
          IDLE: begin
            state   <= ACQUIRE;
            hit_cnt <= '0;
            win_q   <= eye_win;
          end
          ACQUIRE: begin
            if (hit) begin
              hit_cnt <= hit_cnt + 3'd1;
              if (hit_cnt + 3'd1 == LOCK_N) begin
                state <= TRACK;
                win_q <= pupil_win;
                cx    <= cx_next;
                cy    <= cy_next;
                valid <= 1'b1;
              end else begin
                win_q <= eye_win;
              end
            end else begin
              hit_cnt <= '0;
              win_q   <= eye_win;
            end
          end
          TRACK: begin
            if (hit) begin
              win_q <= pupil_win;
              cx    <= cx_next;
              cy    <= cy_next;
              lost  <= '0;
            end else begin
              state <= COAST;
              lost  <= 3'd1;
            end
          end
          COAST: begin
            if (hit) begin
              state <= TRACK;
              lost  <= '0;
              win_q <= pupil_win;
              cx    <= cx_next;
              cy    <= cy_next;
            end else if (lost == LOST_N) begin
              state   <= ACQUIRE;
              lost    <= '0;
              hit_cnt <= '0;
              valid   <= 1'b0;
              win_q   <= eye_win;
            end else begin
              lost <= lost + 3'd1;
            end
          end
        endcase
      end
    end
  end

  assign bus.win_pos_out  = win_q;
  assign bus.track_state  = state;
  assign bus.center_x     = cx;
  assign bus.center_y     = cy;
  assign bus.center_valid = valid;
  assign bus.lost_cnt     = lost;
endmodule

// File: tb/tb_pupil_track_ctrl.sv
// Randomized frame-level bench for pupil_track_ctrl: a per-frame reference model checked every cycle,
// plus directed frames with literal expectations for lock-in, smoothing, clamp, invalid box, drop and reset.
module tb_pupil_track_ctrl;
  localparam int HD = 1280, VD = 720, LOCK = 3, LOSTM = 4;
`ifdef PUPIL_TRACK_SMOOTH_EN
  localparam bit SMOOTH = 1'b1;
`else
  localparam bit SMOOTH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pupil_track_ctrl_if bus();
  pupil_track_ctrl #(.IMG_HDISP(HD), .IMG_VDISP(VD), .LOCK_CNT(LOCK), .LOST_MAX(LOSTM))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0, failures = 0;

  // model state: plain integers per field
  int m_state, m_hits, m_lost, m_valid, m_cx, m_cy;
  int w_f, w_ymax, w_xmax, w_ymin, w_xmin;

  function automatic logic [42:0] mk_box(input int f, input int ymax, input int xmax,
                                         input int ymin, input int xmin);
    logic [42:0] b;
    b[42]    = f[0];
    b[41:32] = ymax[9:0];
    b[31:21] = xmax[10:0];
    b[20:11] = ymin[9:0];
    b[10:0]  = xmin[10:0];
    return b;
  endfunction

  task automatic chk(input string n, input logic [42:0] act, input logic [42:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_hits = 0; m_lost = 0; m_valid = 0; m_cx = 0; m_cy = 0;
    w_f = 0; w_ymax = 0; w_xmax = 0; w_ymin = 0; w_xmin = 0;
  endtask

  task automatic load_win(input int f, input int ymax, input int xmax, input int ymin, input int xmin);
    w_f    = f;
    w_xmin = (xmin < 20) ? 20 : xmin;
    w_ymin = (ymin < 32) ? 32 : ymin;
    w_xmax = (xmax > HD - 21) ? HD - 21 : xmax;
    w_ymax = (ymax > VD - 21) ? VD - 21 : ymax;
  endtask

  task automatic set_centre();
    m_cx = (w_xmin + w_xmax) / 2;
    m_cy = (w_ymin + w_ymax) / 2;
  endtask

  task automatic model_frame(input logic [42:0] eye, input logic [42:0] pupil);
    int pf    = int'(pupil[42]);
    int pymax = int'(pupil[41:32]);
    int pxmax = int'(pupil[31:21]);
    int pymin = int'(pupil[20:11]);
    int pxmin = int'(pupil[10:0]);
    bit hit   = (pf == 1) && (pxmax >= pxmin) && (pymax >= pymin);
    int ef = int'(eye[42]), eymax = int'(eye[41:32]), exmax = int'(eye[31:21]);
    int eymin = int'(eye[20:11]), exmin = int'(eye[10:0]);
    case (m_state)
      0: begin m_state = 1; m_hits = 0; load_win(ef, eymax, exmax, eymin, exmin); end
      1: if (hit) begin
           m_hits++;
           if (m_hits == LOCK) begin
             m_state = 2; m_valid = 1;
             load_win(pf, pymax, pxmax, pymin, pxmin); set_centre();
           end else load_win(ef, eymax, exmax, eymin, exmin);
         end else begin
           m_hits = 0; load_win(ef, eymax, exmax, eymin, exmin);
         end
      2: if (hit) begin
           if (SMOOTH)
             load_win(pf, (w_ymax + pymax) / 2, (w_xmax + pxmax) / 2,
                      (w_ymin + pymin) / 2, (w_xmin + pxmin) / 2);
           else
             load_win(pf, pymax, pxmax, pymin, pxmin);
           set_centre(); m_lost = 0;
         end else begin
           m_state = 3; m_lost = 1;
         end
      default: if (hit) begin
           m_state = 2; m_lost = 0;
           load_win(pf, pymax, pxmax, pymin, pxmin); set_centre();
         end else if (m_lost == LOSTM) begin
           m_state = 1; m_lost = 0; m_hits = 0; m_valid = 0;
           load_win(ef, eymax, exmax, eymin, exmin);
         end else m_lost++;
    endcase
  endtask

  // every cycle: outputs must equal the model, which only moves two cycles after a vsync fall
  always @(negedge clk) begin
    chk("win",   bus.win_pos_out, mk_box(w_f, w_ymax, w_xmax, w_ymin, w_xmin));
    chk("state", 43'(bus.track_state), 43'(m_state));
    chk("cx",    43'(bus.center_x), 43'(m_cx));
    chk("cy",    43'(bus.center_y), 43'(m_cy));
    chk("valid", 43'(bus.center_valid), 43'(m_valid));
    chk("lost",  43'(bus.lost_cnt), 43'(m_lost));
  end

  function automatic logic [42:0] rand_box();
    int k  = $urandom_range(0, 9);
    int x0 = $urandom_range(0, 1200);
    int y0 = $urandom_range(0, 650);
    int x1 = x0 + $urandom_range(0, 80);
    int y1 = y0 + $urandom_range(0, 70);
    if (k < 2) return mk_box(0, y1, x1, y0, x0);
    if (k == 2) return mk_box(1, y0, x0, y0 + 5, x0 + 3);
    if (k == 3) return mk_box(1, $urandom_range(0, 1023), $urandom_range(0, 2047),
                              $urandom_range(0, 1023), $urandom_range(0, 2047));
    return mk_box(1, y1, x1, y0, x0);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_win"},   bus.win_pos_out, 43'd0);
    chk({tag, "_state"}, 43'(bus.track_state), 43'd0);
    chk({tag, "_cx"},    43'(bus.center_x), 43'd0);
    chk({tag, "_cy"},    43'(bus.center_y), 43'd0);
    chk({tag, "_valid"}, 43'(bus.center_valid), 43'd0);
    chk({tag, "_lost"},  43'(bus.lost_cnt), 43'd0);
  endtask

  // called at posedge+1; returns at posedge+1 after a legal blank
  task automatic frame(input logic [42:0] eye, input logic [42:0] pupil, input int act, input bit rst_mid);
    bus.per_frame_vsync = 1'b1;
    for (int i = 0; i < act; i++) begin
      bus.eye_pos_in   = rand_box();
      bus.pupil_pos_in = rand_box();
      if (rst_mid && i == act / 2) begin
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_zero("async_rst");
        @(posedge clk); #1 rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.per_frame_vsync = 1'b0;
    bus.eye_pos_in      = eye;
    bus.pupil_pos_in    = pupil;
    @(posedge clk);
    @(posedge clk); #1;
    model_frame(eye, pupil);
    repeat (1 + $urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  logic [42:0] eye_a, pup_a, pup_s, pup_inv, pup_clamp, pup_nf;

  initial begin
    eye_a     = mk_box(1, 400, 700, 300, 500);
    pup_a     = mk_box(1, 380, 660, 340, 580);
    pup_s     = mk_box(1, 380, 660, 340, 600);
    pup_inv   = mk_box(1, 300, 400, 350, 500);
    pup_clamp = mk_box(1, 715, 1275, 10, 5);
    pup_nf    = mk_box(0, 380, 660, 340, 580);
    bus.per_frame_vsync = 1'b0;
    bus.eye_pos_in      = '0;
    bus.pupil_pos_in    = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end   // vsync low out of reset: no frame end

    // lock-in: first frame leaves IDLE, then three hits lock
    frame(eye_a, pup_a, 6, 1'b0);
    chk("idle_to_acq", 43'(bus.track_state), 43'd1);
    frame(eye_a, pup_a, 6, 1'b0);
    chk("lock_f1", 43'(bus.track_state), 43'd1);
    frame(eye_a, pup_a, 6, 1'b0);
    chk("lock_f2", 43'(bus.track_state), 43'd1);
    frame(eye_a, pup_a, 6, 1'b0);
    chk("lock_f3", 43'(bus.track_state), 43'd2);
    chk("lock_win", bus.win_pos_out, mk_box(1, 380, 660, 340, 580));
    chk("lock_cx", 43'(bus.center_x), 43'd620);
    chk("lock_cy", 43'(bus.center_y), 43'd360);
    chk("lock_valid", 43'(bus.center_valid), 43'd1);

    // smoothing on a TRACK->TRACK hit
    frame(eye_a, pup_s, 5, 1'b0);
    chk("smooth_xmin", 43'(bus.win_pos_out[10:0]), SMOOTH ? 43'd590 : 43'd600);

    // inverted box is a miss
    frame(eye_a, pup_inv, 5, 1'b0);
    chk("inv_state", 43'(bus.track_state), 43'd3);
    chk("inv_lost", 43'(bus.lost_cnt), 43'd1);
    chk("inv_win", bus.win_pos_out, mk_box(1, 380, 660, 340, SMOOTH ? 590 : 600));

    // COAST->TRACK loads directly, so clamp literal holds in both builds
    frame(eye_a, pup_clamp, 5, 1'b0);
    chk("clamp_win", bus.win_pos_out, mk_box(1, 699, 1259, 32, 20));
    chk("clamp_cx", 43'(bus.center_x), 43'd639);
    chk("clamp_cy", 43'(bus.center_y), 43'd365);
    chk("clamp_lost", 43'(bus.lost_cnt), 43'd0);

    // drop: four coasting misses then re-acquire
    for (int i = 1; i <= 4; i++) begin
      frame(eye_a, pup_nf, 4, 1'b0);
      chk("coast_state", 43'(bus.track_state), 43'd3);
      chk("coast_lost", 43'(bus.lost_cnt), 43'(i));
    end
    frame(eye_a, pup_nf, 4, 1'b0);
    chk("drop_state", 43'(bus.track_state), 43'd1);
    chk("drop_valid", 43'(bus.center_valid), 43'd0);
    chk("drop_win", bus.win_pos_out, mk_box(1, 400, 700, 300, 500));

    // relock, then reset mid-frame in TRACK
    repeat (3) frame(eye_a, pup_a, 4, 1'b0);
    chk("relock_state", 43'(bus.track_state), 43'd2);
    frame(eye_a, pup_a, 8, 1'b1);
    chk("post_rst_state", 43'(bus.track_state), 43'd1);

    // randomized frames
    for (int n = 0; n < 400; n++) begin
      logic [42:0] e, p;
      e = rand_box();
      if ($urandom_range(0, 9) == 0) e[42] = 1'b0;
      else e[42] = 1'b1;
      p = rand_box();
      frame(e, p, $urandom_range(3, 12), ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
